cfg_shadow_chain: RTL and testbench
===================================

# cfg_shadow_chain

Parametrised successor to the single-bit configuration shift chain. It holds LENGTH words of WIDTH bits in a serial staging register and adds a shadow (active) configuration register that changes only on an explicit, validated commit. A frame-length counter, a four-state controller and sticky error reporting keep partially or over-shifted bitstreams from ever reaching the fabric. It sits between the configuration loader and the configurable tiles, and cascades through shift_out.

## Interface
- LENGTH, default 8: words in the chain; must be ≥ 1.
- WIDTH, default 1: bits per word (serial lane width); must be ≥ 1.
- CW: local parameter, not overridable, equal to $clog2(LENGTH+1).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- shift_enable  in  1  shift one word this cycle.
- shift_in  in  WIDTH  word entering stage 0.
- shift_out  out  WIDTH  stage LENGTH-1; feeds the next chain.
- commit  in  1  request copy of staging to active config.
- abort  in  1  discard the current frame and clear errors.
- config_data  out  LENGTH*WIDTH  active config; bits [(i+1)*WIDTH-1 : i*WIDTH] = committed stage i.
- config_valid  out  1  high once any commit has succeeded.
- shift_count  out  CW  words shifted in the current frame (0..LENGTH).
- overflow  out  1  sticky; high when more than LENGTH shifts occurred in the frame.
- commit_ack  out  1  one-cycle pulse: commit accepted.
- commit_err  out  1  one-cycle pulse: commit rejected.

## Operation
- Staging: on shift_enable, stage[0] <= shift_in and stage[i] <= stage[i-1]. The first word shifted of a frame ends in stage LENGTH-1.
- Stage and state updates are gated only by shift_enable and control inputs; there is no clock gating.
- States:
  - EMPTY: count = 0.
  - LOADING: 0 < count < LENGTH.
  - FULL: count = LENGTH.
  - ERROR: overflow = 1.
- Transitions, per cycle, highest priority first:
  - abort: count <= 0, overflow <= 0, state <= EMPTY. Stages still shift if shift_enable; that shift is not counted. commit is ignored, with no ack and no err.
  - commit in FULL: config_data <= pre-edge stage contents, config_valid <= 1, commit_ack pulses. count <= 1 if shift_enable (state LOADING), else 0 (state EMPTY).
  - commit in EMPTY, LOADING or ERROR: commit_err pulses. config_data is unchanged. Any shift_enable is processed normally.
  - shift_enable in EMPTY or LOADING: count += 1; state becomes LOADING, or FULL on reaching LENGTH.
  - shift_enable in FULL: overflow <= 1, state <= ERROR, count stays LENGTH (saturates).
  - shift_enable in ERROR: data keeps shifting; count and overflow hold.
- config_data changes only on an accepted commit or on reset.
- Reset (rst = 0), asynchronous: all stages 0, config_data 0, config_valid 0, shift_count 0, overflow 0, commit_ack 0, commit_err 0, state EMPTY.

## Timing
- All outputs are registered. shift_out is stage[LENGTH-1] with no combinational path from shift_in.
- A word presented at edge k appears on shift_out after LENGTH enabled edges (pass-through latency LENGTH shifts).
- config_data, config_valid and commit_ack update on the edge where commit is sampled, so they are visible one cycle after commit is asserted. commit_err follows the same timing.
- shift_count and overflow update on the edge sampling shift_enable.
- Reset asserts immediately, without a clock edge. Deassertion is expected synchronous to clk (synchronised upstream). The first active edge after deassertion may shift.
- Back-to-back commits: the second one is rejected unless LENGTH more shifts occurred in between.

## Test plan
All scenarios use LENGTH=4, WIDTH=2.
- Reset: drive rst=0 mid-frame with no clock edge → config_data=0x00, shift_count=0, overflow=0, config_valid=0, shift_out=0 immediately.
- Full frame: shift words 1,2,3,0, then commit → shift_out=1 after the 4th shift; one cycle after commit, config_data=0x6C, config_valid=1, commit_ack=1 for one cycle, shift_count=0.
- Short frame: shift 3 words, then commit → commit_err=1 for one cycle, commit_ack=0, config_data unchanged, shift_count=3.
- Overflow: shift 5 words → overflow=1 and shift_count=4 after the 5th edge; commit → commit_err. Then abort → overflow=0, shift_count=0; 4 further shifts plus commit → ack.
- Simultaneous commit and shift in FULL with staging {1,2,3,0}, shift_in=2 → config_data=0x6C (pre-shift contents), shift_count=1, no overflow.
- Abort with commit and shift_enable in the same cycle, state FULL → no ack, no err, shift_count=0, config_data unchanged, stages shifted once.

Source files
------------

// File: rtl/cfg_shadow_chain.sv
// cfg_shadow_chain: serial configuration staging chain with a validated shadow (active) register.
module cfg_shadow_chain #(
   parameter int LENGTH = 8,
   parameter int WIDTH = 1,
   localparam int CW = $clog2(LENGTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    shift_enable,
   input  logic [WIDTH-1:0]        shift_in,
   output logic [WIDTH-1:0]        shift_out,
   input  logic                    commit,
   input  logic                    abort,
   output logic [LENGTH*WIDTH-1:0] config_data,
   output logic                    config_valid,
   output logic [CW-1:0]           shift_count,
   output logic                    overflow,
   output logic                    commit_ack,
   output logic                    commit_err
);
   typedef enum logic [1:0] {EMPTY, LOADING, FULL, ERROR} state_t;
   localparam logic [CW-1:0] LAST_CNT = CW'(LENGTH - 1);
   state_t state, state_d;
   logic [WIDTH-1:0] stage [LENGTH];
   logic [LENGTH*WIDTH-1:0] stage_flat;
   logic [CW-1:0] count_d;
   logic ovf_d, ack_d, err_d, load;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LENGTH; i++) stage[i] <= '0;
      end else if (shift_enable) begin
         stage[0] <= shift_in;
         for (int i = 1; i < LENGTH; i++) stage[i] <= stage[i-1];
      end
   end
   always_comb begin
      stage_flat = '0;
      for (int i = 0; i < LENGTH; i++) stage_flat[i*WIDTH +: WIDTH] = stage[i];
   end
   assign shift_out = stage[LENGTH-1];
   // abort beats commit beats shift; a shift under abort still moves data but is not counted
   always_comb begin
      state_d = state;
      count_d = shift_count;
      ovf_d = overflow;
      ack_d = 1'b0;
      err_d = 1'b0;
      load = 1'b0;
      if (abort) begin
         state_d = EMPTY;
         count_d = '0;
         ovf_d = 1'b0;
      end else if (commit && state == FULL) begin
         load = 1'b1;
         ack_d = 1'b1;
         count_d = shift_enable ? CW'(1) : '0;
         state_d = !shift_enable ? EMPTY : (LENGTH == 1 ? FULL : LOADING);
      end else begin
         err_d = commit;
         if (shift_enable) begin
            if (state == EMPTY || state == LOADING) begin
               count_d = shift_count + CW'(1);
               state_d = shift_count == LAST_CNT ? FULL : LOADING;
            end else if (state == FULL) begin
               ovf_d = 1'b1;
               state_d = ERROR;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= EMPTY;
         shift_count <= '0;
         overflow <= 1'b0;
         commit_ack <= 1'b0;
         commit_err <= 1'b0;
         config_data <= '0;
         config_valid <= 1'b0;
      end else begin
         state <= state_d;
         shift_count <= count_d;
         overflow <= ovf_d;
         commit_ack <= ack_d;
         commit_err <= err_d;
         if (load) begin
            config_data <= stage_flat;
            config_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cfg_shadow_chain.sv
// tb_cfg_shadow_chain: directed vectors with a scoreboard of expected commit responses.
module tb_cfg_shadow_chain;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic shift_enable = 1'b0;
   logic [1:0] shift_in = '0;
   logic commit = 1'b0;
   logic abort = 1'b0;
   logic [1:0] shift_out;
   logic [7:0] config_data;
   logic config_valid;
   logic [2:0] shift_count;
   logic overflow;
   logic commit_ack;
   logic commit_err;
   typedef struct {
      logic ack;
      logic [7:0] data;
      logic valid;
      logic [2:0] cnt;
   } exp_t;
   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;
   cfg_shadow_chain #(.LENGTH(4), .WIDTH(2)) dut (
      .clk(clk), .rst(rst), .shift_enable(shift_enable), .shift_in(shift_in),
      .shift_out(shift_out), .commit(commit), .abort(abort), .config_data(config_data),
      .config_valid(config_valid), .shift_count(shift_count), .overflow(overflow),
      .commit_ack(commit_ack), .commit_err(commit_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic step(input logic se, input logic [1:0] si, input logic cm, input logic ab);
      shift_enable = se;
      shift_in = si;
      commit = cm;
      abort = ab;
      @(posedge clk);
      #1;
      shift_enable = 1'b0;
      commit = 1'b0;
      abort = 1'b0;
   endtask
   task automatic expect_resp(input logic ack, input logic [7:0] data, input logic [2:0] cnt);
      exp_t e;
      e.ack = ack;
      e.data = data;
      e.valid = 1'b1;
      e.cnt = cnt;
      sb.push_back(e);
   endtask
   task automatic frame(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
      step(1, a, 0, 0);
      step(1, b, 0, 0);
      step(1, c, 0, 0);
      step(1, d, 0, 0);
   endtask
   // monitor: every ack/err pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (commit_ack || commit_err) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: got ack=%0b err=%0b, expected none", commit_ack, commit_err);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_kind", {30'd0, commit_ack, commit_err}, {30'd0, e.ack, ~e.ack});
            chk("resp_config_data", {24'd0, config_data}, {24'd0, e.data});
            chk("resp_config_valid", {31'd0, config_valid}, {31'd0, e.valid});
            chk("resp_shift_count", {29'd0, shift_count}, {29'd0, e.cnt});
         end
      end
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_config_data", {24'd0, config_data}, 32'h00);
      chk("reset_shift_count", {29'd0, shift_count}, 0);
      chk("reset_overflow", {31'd0, overflow}, 0);
      chk("reset_config_valid", {31'd0, config_valid}, 0);
      rst = 1'b1;
      step(1, 1, 0, 0);
      step(1, 2, 0, 0);
      step(1, 3, 0, 0);
      chk("full_shift_out_3", {30'd0, shift_out}, 0);
      step(1, 0, 0, 0);
      chk("full_shift_out_4", {30'd0, shift_out}, 1);
      chk("full_count", {29'd0, shift_count}, 4);
      expect_resp(1, 8'h6C, 0);
      step(0, 0, 1, 0);
      chk("full_after_commit_count", {29'd0, shift_count}, 0);
      step(0, 0, 0, 0);
      chk("ack_one_cycle", {31'd0, commit_ack}, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      expect_resp(0, 8'h6C, 3);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("err_one_cycle", {31'd0, commit_err}, 0);
      chk("short_count", {29'd0, shift_count}, 3);
      step(0, 0, 0, 1);
      frame(2, 3, 1, 0);
      chk("ovf_before", {31'd0, overflow}, 0);
      step(1, 2, 0, 0);
      chk("ovf_set", {31'd0, overflow}, 1);
      chk("ovf_count_sat", {29'd0, shift_count}, 4);
      expect_resp(0, 8'h6C, 4);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      chk("abort_clears_ovf", {31'd0, overflow}, 0);
      chk("abort_clears_count", {29'd0, shift_count}, 0);
      frame(3, 0, 1, 2);
      expect_resp(1, 8'hC6, 0);
      step(0, 0, 1, 0);
      frame(1, 2, 3, 0);
      expect_resp(1, 8'h6C, 1);
      step(1, 2, 1, 0);
      chk("simul_count", {29'd0, shift_count}, 1);
      chk("simul_no_ovf", {31'd0, overflow}, 0);
      chk("simul_shift_out", {30'd0, shift_out}, 2);
      step(0, 0, 0, 1);
      frame(1, 2, 3, 0);
      step(1, 3, 1, 1);
      chk("abortmix_count", {29'd0, shift_count}, 0);
      chk("abortmix_data", {24'd0, config_data}, 32'h6C);
      chk("abortmix_shifted", {30'd0, shift_out}, 2);
      expect_resp(0, 8'h6C, 0);
      step(0, 0, 1, 0);
      step(1, 2, 0, 0);
      step(1, 1, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      chk("async_config_data", {24'd0, config_data}, 32'h00);
      chk("async_shift_count", {29'd0, shift_count}, 0);
      chk("async_overflow", {31'd0, overflow}, 0);
      chk("async_config_valid", {31'd0, config_valid}, 0);
      chk("async_shift_out", {30'd0, shift_out}, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
